// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with a valid/ready handshake on both sides.
//   Single-cycle ops (add/sub/logic/shifts/compares/branches) finish in one cycle.
//   MULU uses a shift-add loop and DIVU a restoring loop, WIDTH iterations each.
//   DIVU by zero short-circuits to quotient all ones, remainder = a, div_zero = 1.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operation offer / block idle and able to accept
//   op, a, b, shamt            operation select, operands, shift amount
//   out_valid / out_ready      result held in registers / consumer takes it
//   result, result_hi          low result (product low, quotient) / high product or remainder
//   branch, div_zero           branch decision / DIVU with b == 0
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             branch,
    output logic             div_zero
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_BEQ  = 4'd12;
    localparam logic [3:0] OP_BNE  = 4'd13;
    localparam logic [3:0] OP_BLT  = 4'd14;
    localparam logic [3:0] OP_BGE  = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    // Single-cycle ALU value; branch ops and the iterative ops yield 0 here.
    function automatic logic [WIDTH-1:0] alu_value(
        input logic [3:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b,
        input logic [SHW-1:0]   f_sh
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = f_a;
        sb = f_b;
        case (f_op)
            OP_ADD:  return f_a + f_b;
            OP_SUB:  return f_a - f_b;
            OP_AND:  return f_a & f_b;
            OP_OR:   return f_a | f_b;
            OP_XOR:  return f_a ^ f_b;
            OP_SLL:  return f_a << f_sh;
            OP_SRL:  return f_a >> f_sh;
            OP_SRA:  return sa >>> f_sh;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (f_a < f_b)};
            default: return '0;
        endcase
    endfunction

    function automatic logic branch_value(
        input logic [3:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = f_a;
        sb = f_b;
        case (f_op)
            OP_BEQ:  return f_a == f_b;
            OP_BNE:  return f_a != f_b;
            OP_BLT:  return sa < sb;
            OP_BGE:  return sa >= sb;
            default: return 1'b0;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;      // {hi, lo}: product/multiplier or remainder/quotient
    logic [WIDTH-1:0]     opb_q, opb_d;      // multiplicand or divisor
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 branch_q, branch_d;
    logic                 div_zero_q, div_zero_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;

    // One iteration of each loop, computed from the accumulator every cycle.
    always_comb begin
        // Add the multiplicand into the high half when the current multiplier LSB
        // is set, then shift the whole accumulator right keeping the carry.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc_q[0]}} & {1'b0, opb_q});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Shift the next dividend bit into the partial remainder and subtract;
        // a borrow in the top bit means restore (keep the shifted remainder).
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        branch_d    = branch_q;
        div_zero_d  = div_zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opb_d = b;
                    cnt_d = SHW'(WIDTH - 1);
                    acc_d = {{WIDTH{1'b0}}, a};
                    if (op == OP_MULU) begin
                        state_d = S_MUL;
                    end else if (op == OP_DIVU && b != '0) begin
                        state_d = S_DIV;
                    end else begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        if (op == OP_DIVU) begin
                            result_d    = '1;
                            result_hi_d = a;
                            branch_d    = 1'b0;
                            div_zero_d  = 1'b1;
                        end else begin
                            result_d    = alu_value(op, a, b, shamt);
                            result_hi_d = '0;
                            branch_d    = branch_value(op, a, b);
                            div_zero_d  = 1'b0;
                        end
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_next : div_next;
                if (cnt_q == '0) begin
                    // Last iteration: publish straight from the next accumulator value.
                    result_d    = acc_d[WIDTH-1:0];
                    result_hi_d = acc_d[2*WIDTH-1:WIDTH];
                    branch_d    = 1'b0;
                    div_zero_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            branch_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            branch_q    <= branch_d;
            div_zero_q  <= div_zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign branch    = branch_q;
    assign div_zero  = div_zero_q;

endmodule
